// File: rtl/trigger_pkg.sv
// Shared constants, FSM encoding and packet-word builders for the trigger event packer.
package trigger_pkg;

  localparam logic [7:0] HDR_MARK = 8'hA5;
  localparam logic [7:0] TRL_MARK = 8'h5A;
  localparam int         CNT_W    = 15;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_CAPTURE = 1'b1
  } state_t;

  function automatic logic [31:0] header_word(input logic [7:0] idx);
    return {HDR_MARK, idx, 16'h0000};
  endfunction

  function automatic logic [31:0] trailer_word(input logic [7:0] idx, input logic ovf,
                                               input logic [CNT_W-1:0] cnt);
    return {TRL_MARK, idx, ovf, cnt};
  endfunction

endpackage

// File: rtl/event_fifo.sv
// Synchronous show-ahead FIFO with a registered output word and a free-entry count.
module event_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     rd_valid,
  output logic [$clog2(DEPTH):0]   free
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg, head_idx;
  logic [AW:0]      count_reg, count_next, remaining;
  logic [WIDTH-1:0] out_reg, out_next;
  logic             valid_reg;
  logic             rd_fire, wr_fire;

  assign rd_fire   = valid_reg & rd_en;
  assign wr_fire   = wr_en & ((count_reg != DEPTH_L) | rd_fire);
  assign remaining = count_reg - {{AW{1'b0}}, rd_fire};
  assign head_idx  = rd_ptr_reg + {{(AW-1){1'b0}}, rd_fire};
  assign free      = DEPTH_L - count_reg;
  assign rd_data   = out_reg;
  assign rd_valid  = valid_reg;

  // The output register mirrors the head entry; when no older entry survives the read,
  // the head is the word being written this cycle.
  always_comb begin
    count_next = count_reg + {{AW{1'b0}}, wr_fire} - {{AW{1'b0}}, rd_fire};
    out_next   = out_reg;
    if (remaining != '0)
      out_next = mem[head_idx];
    else if (wr_fire)
      out_next = wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      out_reg    <= '0;
      valid_reg  <= 1'b0;
    end else begin
      if (wr_fire) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (rd_fire) rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_next;
      out_reg   <= out_next;
      valid_reg <= (count_next != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_fire) mem[wr_ptr_reg] <= wr_data;
  end

endmodule

// File: rtl/trigger_event_packer.sv
// Packs data words seen during a trigger window into header/data/trailer packets.
module trigger_event_packer
  import trigger_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              trigger,
  input  logic [7:0]        trigger_index,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [15:0]       event_count,
  output logic [15:0]       event_drop_count
);

  localparam int FW = $clog2(FIFO_DEPTH) + 1;

  state_t             state_reg, state_next;
  logic               trig_prev_reg;
  logic [7:0]         idx_reg, idx_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic               ovf_reg, ovf_next;
  logic [15:0]        ev_reg, ev_next, drop_reg, drop_next;
  logic               wr_en;
  logic [DATA_W:0]    wr_word;
  logic [DATA_W:0]    fifo_rd;
  logic [FW-1:0]      free;
  logic               rise;

  assign rise             = trigger & ~trig_prev_reg;
  assign out_data         = fifo_rd[DATA_W-1:0];
  assign out_last         = fifo_rd[DATA_W];
  assign event_count      = ev_reg;
  assign event_drop_count = drop_reg;

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    cnt_next   = cnt_reg;
    ovf_next   = ovf_reg;
    ev_next    = ev_reg;
    drop_next  = drop_reg;
    wr_en      = 1'b0;
    wr_word    = '0;
    case (state_reg)
      ST_IDLE: begin
        if (rise) begin
          if (free >= FW'(2)) begin
            wr_en      = 1'b1;
            wr_word    = {1'b0, header_word(trigger_index)};
            idx_next   = trigger_index;
            cnt_next   = '0;
            ovf_next   = 1'b0;
            ev_next    = ev_reg + 16'd1;
            state_next = ST_CAPTURE;
          end else if (drop_reg != 16'hFFFF) begin
            drop_next = drop_reg + 16'd1;
          end
        end
      end
      ST_CAPTURE: begin
        if (!trigger) begin
          wr_en      = 1'b1;
          wr_word    = {1'b1, trailer_word(idx_reg, ovf_reg, cnt_reg)};
          state_next = ST_IDLE;
        end else if (data_valid) begin
          // One entry stays reserved so the trailer always fits.
          if (free > FW'(1)) begin
            wr_en   = 1'b1;
            wr_word = {1'b0, data_in};
            if (cnt_reg != {CNT_W{1'b1}}) cnt_next = cnt_reg + 1'b1;
          end else begin
            ovf_next = 1'b1;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      trig_prev_reg <= 1'b1;
      idx_reg       <= '0;
      cnt_reg       <= '0;
      ovf_reg       <= 1'b0;
      ev_reg        <= '0;
      drop_reg      <= '0;
    end else begin
      state_reg     <= state_next;
      trig_prev_reg <= trigger;
      idx_reg       <= idx_next;
      cnt_reg       <= cnt_next;
      ovf_reg       <= ovf_next;
      ev_reg        <= ev_next;
      drop_reg      <= drop_next;
    end
  end

  event_fifo #(
    .WIDTH(DATA_W + 1),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_data (wr_word),
    .rd_en   (out_ready),
    .rd_data (fifo_rd),
    .rd_valid(out_valid),
    .free    (free)
  );

endmodule
